// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the alarm tone generator.
//   note_t         one melody entry (tone half period in clocks, duration units)
//   melody_t       eight-entry melody table, entry 0 in the low bits
//   MELODY_DEFAULT default tune, half periods computed for a 50 MHz clock
//   tone_state_t   playback FSM states
//   eff_dur()      duration with 0 promoted to 1
package alarm_pkg;

  typedef struct packed {
    logic [15:0] half_period;  // 0 = rest
    logic [3:0]  dur;          // duration units, 0 behaves as 1
  } note_t;

  typedef note_t [7:0] melody_t;

  // Concatenation lists entry 7 first so that entry 0 lands in the low bits.
  localparam melody_t MELODY_DEFAULT = {
    note_t'{16'd0,     4'd4},  // 7: rest
    note_t'{16'd23900, 4'd4},  // 6: C6
    note_t'{16'd31888, 4'd2},  // 5: G5
    note_t'{16'd0,     4'd1},  // 4: rest
    note_t'{16'd23900, 4'd4},  // 3: C6
    note_t'{16'd31888, 4'd2},  // 2: G5
    note_t'{16'd37922, 4'd2},  // 1: E5
    note_t'{16'd47801, 4'd2}   // 0: C5
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } tone_state_t;

  function automatic logic [3:0] eff_dur(input logic [3:0] dur);
    return (dur == 4'd0) ? 4'd1 : dur;
  endfunction

endpackage

// File: rtl/alarm_tone_gen_square_div.sv
// square_div: programmable square-wave divider.
//   pclk_i/prst_i  clock, asynchronous active-high reset
//   clr            clears counter and square (takes priority over en)
//   en             advance the half-period counter
//   half_period    clocks per half cycle; 0 freezes the output
//   square         square-wave output, toggles at the terminal count
module square_div (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] half_period,
  output logic        square
);

  logic [15:0] cnt_reg;
  logic        square_reg;

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      cnt_reg    <= 16'd0;
      square_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg    <= 16'd0;
      square_reg <= 1'b0;
    end else if (en && (half_period != 16'd0)) begin
      if (cnt_reg == half_period - 16'd1) begin
        cnt_reg    <= 16'd0;
        square_reg <= ~square_reg;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign square = square_reg;

endmodule

// File: rtl/alarm_tone_gen.sv
// alarm_tone_gen: plays a looping melody once per alarm-match rising edge.
//   pclk_i      clock
//   prst_i      asynchronous active-high reset
//   ring_i      alarm-match level; a rising edge starts playback
//   stop_i      single-cycle dismiss pulse
//   volume_i    PWM duty (0 silent, 255 -> 255/256)
//   aud_pwm_o   registered audio pin drive
//   ringing_o   high while a note or inter-note gap is playing
//   note_idx_o  index of the current melody entry
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 5_000_000,
  parameter int unsigned GAP_TICKS  = 500_000,
  parameter int unsigned MAX_LOOPS  = 30,
  parameter melody_t     MELODY     = MELODY_DEFAULT
) (
  input  logic       pclk_i,
  input  logic       prst_i,
  input  logic       ring_i,
  input  logic       stop_i,
  input  logic [7:0] volume_i,
  output logic       aud_pwm_o,
  output logic       ringing_o,
  output logic [2:0] note_idx_o
);

  localparam int NCW = $clog2(15 * NOTE_TICKS);
  localparam int GCW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int LCW = (MAX_LOOPS > 0) ? $clog2(MAX_LOOPS + 1) : 1;

  tone_state_t    state_reg;
  logic           ring_q_reg;
  logic           ring_valid_reg;
  logic [2:0]     note_idx_reg;
  logic [NCW-1:0] note_cnt_reg;
  logic [GCW-1:0] gap_cnt_reg;
  logic [LCW-1:0] loop_cnt_reg;
  logic           ringing_reg;
  logic [7:0]     pwm_cnt_reg;
  logic           aud_pwm_reg;

  note_t          cur_note;
  logic [NCW-1:0] note_last;
  logic           note_end;
  logic           gap_end;
  logic           ring_rise;
  logic           melody_wrap;
  logic           loops_done;
  logic           square;
  logic           pwm_on;

  assign cur_note  = MELODY[note_idx_reg];
  assign note_last = NCW'(32'(eff_dur(cur_note.dur)) * NOTE_TICKS - 32'd1);
  assign note_end  = (note_cnt_reg == note_last);
  assign gap_end   = (gap_cnt_reg == GCW'(GAP_TICKS - 1));

  // ring_q is meaningless until ring_i has been seen low once after reset;
  // without this qualifier a level that is already high at reset release
  // would look like a fresh edge and ring a second time in the same minute.
  assign ring_rise = ring_i & ~ring_q_reg & ring_valid_reg;

  assign melody_wrap = (note_idx_reg == 3'd7);
  assign loops_done  = melody_wrap && (MAX_LOOPS != 0) &&
                       (loop_cnt_reg == LCW'(MAX_LOOPS - 1));

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_reg      <= ST_IDLE;
      ring_q_reg     <= 1'b0;
      ring_valid_reg <= 1'b0;
      note_idx_reg   <= 3'd0;
      note_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      loop_cnt_reg   <= '0;
      ringing_reg    <= 1'b0;
    end else begin
      ring_q_reg <= ring_i;
      if (!ring_i) begin
        ring_valid_reg <= 1'b1;
      end

      unique case (state_reg)
        ST_IDLE: begin
          if (ring_rise) begin
            note_idx_reg <= 3'd0;
            note_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            loop_cnt_reg <= '0;
            if (stop_i) begin
              state_reg   <= ST_DONE;
              ringing_reg <= 1'b0;
            end else begin
              state_reg   <= ST_PLAY;
              ringing_reg <= 1'b1;
            end
          end
        end

        ST_PLAY: begin
          if (stop_i) begin
            state_reg   <= ST_DONE;
            ringing_reg <= 1'b0;
          end else if (note_end) begin
            note_cnt_reg <= '0;
            if (GAP_TICKS != 0) begin
              state_reg   <= ST_GAP;
              gap_cnt_reg <= '0;
            end else if (loops_done) begin
              state_reg   <= ST_DONE;
              ringing_reg <= 1'b0;
            end else begin
              // No gap: step straight to the next note, staying in PLAY.
              note_idx_reg <= note_idx_reg + 3'd1;
              if (melody_wrap && (MAX_LOOPS != 0)) begin
                loop_cnt_reg <= loop_cnt_reg + LCW'(1);
              end
            end
          end else begin
            note_cnt_reg <= note_cnt_reg + NCW'(1);
          end
        end

        ST_GAP: begin
          if (stop_i) begin
            state_reg   <= ST_DONE;
            ringing_reg <= 1'b0;
          end else if (gap_end) begin
            gap_cnt_reg <= '0;
            if (loops_done) begin
              state_reg   <= ST_DONE;
              ringing_reg <= 1'b0;
            end else begin
              state_reg    <= ST_PLAY;
              note_idx_reg <= note_idx_reg + 3'd1;
              if (melody_wrap && (MAX_LOOPS != 0)) begin
                loop_cnt_reg <= loop_cnt_reg + LCW'(1);
              end
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GCW'(1);
          end
        end

        ST_DONE: begin
          if (!ring_i) begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          ringing_reg <= 1'b0;
        end
      endcase
    end
  end

  // The divider is held clear outside PLAY and on the last clock of every
  // note, so each note (including back-to-back notes with no gap) starts
  // from phase 0.
  square_div u_square_div (
    .pclk_i      (pclk_i),
    .prst_i      (prst_i),
    .clr         ((state_reg != ST_PLAY) | note_end),
    .en          (state_reg == ST_PLAY),
    .half_period (cur_note.half_period),
    .square      (square)
  );

  assign pwm_on = (pwm_cnt_reg < volume_i);

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      pwm_cnt_reg <= 8'd0;
      aud_pwm_reg <= 1'b0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      aud_pwm_reg <= (state_reg == ST_PLAY) & square & pwm_on &
                     (cur_note.half_period != 16'd0);
    end
  end

  assign aud_pwm_o  = aud_pwm_reg;
  assign ringing_o  = ringing_reg;
  assign note_idx_o = note_idx_reg;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// tb_alarm_tone_gen: directed sequence with randomized volumes/delays,
// checked every clock against a timeline model of the melody.
module tb_alarm_tone_gen;
  import alarm_pkg::*;

  localparam int NT   = 10;
  localparam int GT   = 2;
  localparam int MAXL = 2;

  localparam melody_t TB_MELODY = {
    note_t'{16'd4, 4'd1}, note_t'{16'd3, 4'd1}, note_t'{16'd3, 4'd1},
    note_t'{16'd3, 4'd1}, note_t'{16'd5, 4'd1}, note_t'{16'd2, 4'd2},
    note_t'{16'd0, 4'd1}, note_t'{16'd3, 4'd1}
  };

  // Reference note table, entry 0 first, kept separately from TB_MELODY.
  int hp_tab  [8] = '{3, 0, 2, 5, 3, 3, 3, 4};
  int dur_tab [8] = '{1, 1, 2, 1, 1, 1, 1, 1};

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_DONE   = 2;

  logic       pclk = 1'b0;
  logic       prst = 1'b1;
  logic       ring = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] vol  = 8'd0;
  logic       aud_pwm;
  logic       ringing;
  logic [2:0] note_idx;

  int n_vec = 0;
  int n_err = 0;

  // Model state, describing the current clock cycle.
  int m_mode    = M_IDLE;
  int m_elapsed = 0;
  bit m_prev    = 1'b0;
  bit m_armed   = 1'b0;
  int m_pwm     = 0;
  bit exp_aud   = 1'b0;
  int loop_len  = 0;

  alarm_tone_gen #(
    .NOTE_TICKS (NT),
    .GAP_TICKS  (GT),
    .MAX_LOOPS  (MAXL),
    .MELODY     (TB_MELODY)
  ) dut (
    .pclk_i     (pclk),
    .prst_i     (prst),
    .ring_i     (ring),
    .stop_i     (stop),
    .volume_i   (vol),
    .aud_pwm_o  (aud_pwm),
    .ringing_o  (ringing),
    .note_idx_o (note_idx)
  );

  always #5 pclk = ~pclk;

  // Where in the melody timeline a given number of clocks since start lies.
  function automatic void locate(input int e, output bit in_play,
                                 output int idx, output int k);
    int pos;
    int len;
    pos = e % loop_len;
    in_play = 1'b0;
    idx = 0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      len = ((dur_tab[i] == 0) ? 1 : dur_tab[i]) * NT;
      if (pos < len) begin
        in_play = 1'b1;
        idx = i;
        k = pos;
        return;
      end
      pos -= len;
      if (pos < GT) begin
        idx = i;
        return;
      end
      pos -= GT;
    end
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    bit ip;
    int idx;
    int k;
    int hp;
    exp_aud = 1'b0;
    if (m_mode == M_ACTIVE) begin
      locate(m_elapsed, ip, idx, k);
      hp = hp_tab[idx];
      if (ip && hp != 0 && ((k / hp) % 2 == 1) && (m_pwm < int'(vol)))
        exp_aud = 1'b1;
    end
    case (m_mode)
      M_IDLE: begin
        if (ring && !m_prev && m_armed) begin
          m_mode = stop ? M_DONE : M_ACTIVE;
          m_elapsed = 0;
        end
      end
      M_ACTIVE: begin
        if (stop) begin
          m_mode = M_DONE;
        end else begin
          m_elapsed++;
          if (MAXL != 0 && m_elapsed >= MAXL * loop_len) m_mode = M_DONE;
        end
      end
      default: begin
        if (!ring) m_mode = M_IDLE;
      end
    endcase
    if (!ring) m_armed = 1'b1;
    m_prev = ring;
    m_pwm = (m_pwm + 1) % 256;
  endtask

  task automatic step();
    bit ip;
    int idx;
    int k;
    bit exp_ring;
    model_edge();
    @(posedge pclk);
    #1;
    exp_ring = (m_mode == M_ACTIVE);
    n_vec++;
    assert (aud_pwm === exp_aud)
    else begin
      n_err++;
      $error("FAIL aud_pwm t=%0t observed=%0b expected=%0b", $time, aud_pwm, exp_aud);
    end
    n_vec++;
    assert (ringing === exp_ring)
    else begin
      n_err++;
      $error("FAIL ringing t=%0t observed=%0b expected=%0b", $time, ringing, exp_ring);
    end
    if (exp_ring) begin
      locate(m_elapsed, ip, idx, k);
      n_vec++;
      assert (note_idx === 3'(idx))
      else begin
        n_err++;
        $error("FAIL note_idx t=%0t observed=%0d expected=%0d", $time, note_idx, idx);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_rand_vol(input int n);
    for (int i = 0; i < n; i++) begin
      vol = 8'($urandom_range(0, 255));
      step();
    end
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    assert (aud_pwm === 1'b0 && ringing === 1'b0 && note_idx === 3'd0)
    else begin
      n_err++;
      $error("FAIL %s observed=aud%0b/ring%0b/idx%0d expected=0/0/0",
             tag, aud_pwm, ringing, note_idx);
    end
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset();
    #2 prst = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge pclk);
    @(posedge pclk);
    #2 prst = 1'b0;
    m_mode  = M_IDLE;
    m_prev  = 1'b0;
    m_armed = 1'b0;
    m_pwm   = 0;
  endtask

  initial begin
    loop_len = 0;
    for (int i = 0; i < 8; i++)
      loop_len += ((dur_tab[i] == 0) ? 1 : dur_tab[i]) * NT + GT;

    // Power-on reset.
    @(posedge pclk);
    @(posedge pclk);
    #2 prst = 1'b0;
    check_zero("reset_state");
    run(3);

    // Full ring at max volume through both loops, then held high: no restart.
    vol = 8'd255;
    ring = 1'b1;
    run(MAXL * loop_len + 10);
    run(100);

    // Drop and re-raise: restarts at note 0; stop pulse somewhere in note 3.
    ring = 1'b0;
    run(3);
    ring = 1'b1;
    run_rand_vol(46 + $urandom_range(1, 8));
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(5);
    ring = 1'b0;
    run(3);

    // Stop while idle with no edge is ignored.
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(2);

    // Stop coincident with the rising edge: never rings.
    vol = 8'd255;
    ring = 1'b1;
    stop = 1'b1;
    step();
    stop = 1'b0;
    run(30);
    ring = 1'b0;
    run(2 + $urandom_range(0, 3));

    // Silent volume; ring falls mid-play and playback continues to the end.
    vol = 8'd0;
    ring = 1'b1;
    run(60);
    ring = 1'b0;
    run(MAXL * loop_len - 50);

    // Quarter volume over a full loop.
    vol = 8'd64;
    ring = 1'b1;
    run(loop_len + 20);
    ring = 1'b0;
    run_rand_vol(20);

    // Random volume, reset mid-note with ring held high.
    ring = 1'b1;
    run_rand_vol(30 + $urandom_range(0, 20));
    mid_reset();
    vol = 8'd255;
    run(20);
    ring = 1'b0;
    run(2);
    ring = 1'b1;
    run_rand_vol(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
